// File: rtl/pci_io_target.sv
// PCI I/O-space target exposing NUM_REGS 32-bit registers.
// Single data phase per access; every bus output comes straight from a flop.
module pci_io_target #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0200,
    parameter int          NUM_REGS  = 4,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [31:0]              AD_I,
    output logic [31:0]              AD_O,
    output logic [3:0]               OE_AD_N,
    input  logic [3:0]               CBE_I,
    input  logic                     FRAME_I_N,
    input  logic                     IRDY_I_N,
    output logic                     PAR_O,
    output logic                     OE_PAR_N,
    output logic                     DEVSEL_O_N,
    output logic                     OE_DEVSEL_N,
    output logic                     TRDY_O_N,
    output logic                     OE_TRDY_N,
    output logic                     STOP_O_N,
    output logic                     OE_STOP_N,
    output logic [32*NUM_REGS-1:0]   REG_Q,
    output logic [NUM_REGS-1:0]      WR_STB
);

    localparam int          IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
    localparam logic [29:0] NUM_WORDS = 30'(NUM_REGS);
    localparam logic [3:0]  CMD_IO_RD = 4'b0010;
    localparam logic [3:0]  CMD_IO_WR = 4'b0011;

    typedef enum logic [2:0] {
        IDLE, BUSY, WR_DATA, RD_TURN, RD_DATA, BACKOFF, TURNAR
    } state_t;

    state_t                      state;
    logic [NUM_REGS-1:0][31:0]   regs;
    logic [IDX_W-1:0]            idx;
    logic                        frame_q;
    logic [29:0]                 word_off;
    logic                        dec_hit;
    logic [IDX_W-1:0]            dec_idx;

    assign REG_Q = regs;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        word_off = AD_I[31:2] - BASE_WORD;
        dec_hit  = (AD_I[31:2] >= BASE_WORD) && (word_off < NUM_WORDS);
        dec_idx  = word_off[IDX_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK) begin
        // An address phase is only genuine when FRAME was high the cycle before;
        // this also makes the first cycle after reset wait out a transaction in flight.
        frame_q <= FRAME_I_N;
        if (RST) begin
            state       <= IDLE;
            idx         <= '0;
            // NOTE: the register file is reset because software may read it before any write.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
            WR_STB      <= '0;
            AD_O        <= '0;
            OE_AD_N     <= 4'b1111;
            PAR_O       <= 1'b0;
            OE_PAR_N    <= 1'b1;
            DEVSEL_O_N  <= 1'b1;
            OE_DEVSEL_N <= 1'b1;
            TRDY_O_N    <= 1'b1;
            OE_TRDY_N   <= 1'b1;
            STOP_O_N    <= 1'b1;
            OE_STOP_N   <= 1'b1;
        end else begin
            WR_STB <= '0;
            if (OE_AD_N == 4'b0000) begin
                PAR_O    <= ^{AD_O, CBE_I};
                OE_PAR_N <= 1'b0;
            end else begin
                PAR_O    <= 1'b0;
                OE_PAR_N <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (!FRAME_I_N) begin
                        if (frame_q && dec_hit && CBE_I == CMD_IO_WR) begin
                            state       <= WR_DATA;
                            idx         <= dec_idx;
                            DEVSEL_O_N  <= 1'b0;
                            OE_DEVSEL_N <= 1'b0;
                            TRDY_O_N    <= 1'b0;
                            OE_TRDY_N   <= 1'b0;
                            OE_STOP_N   <= 1'b0;
                        end else if (frame_q && dec_hit && CBE_I == CMD_IO_RD) begin
                            state       <= RD_TURN;
                            idx         <= dec_idx;
                            DEVSEL_O_N  <= 1'b0;
                            OE_DEVSEL_N <= 1'b0;
                            OE_TRDY_N   <= 1'b0;
                            OE_STOP_N   <= 1'b0;
                            OE_AD_N     <= 4'b0000;
                            AD_O        <= regs[dec_idx];
                        end else begin
                            state <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    if (FRAME_I_N && IRDY_I_N) state <= IDLE;
                end

                WR_DATA: begin
                    if (!IRDY_I_N && !TRDY_O_N) begin
                        for (int b = 0; b < 4; b++)
                            if (!CBE_I[b]) regs[idx][8*b +: 8] <= AD_I[8*b +: 8];
                        WR_STB[idx] <= 1'b1;
                        TRDY_O_N    <= 1'b1;
                        if (!FRAME_I_N) begin
                            state    <= BACKOFF;
                            STOP_O_N <= 1'b0;
                        end else begin
                            state      <= TURNAR;
                            DEVSEL_O_N <= 1'b1;
                        end
                    end else if (FRAME_I_N && IRDY_I_N) begin
                        state      <= TURNAR;
                        DEVSEL_O_N <= 1'b1;
                        TRDY_O_N   <= 1'b1;
                    end
                end

                RD_TURN: begin
                    if (FRAME_I_N && IRDY_I_N) begin
                        state      <= TURNAR;
                        DEVSEL_O_N <= 1'b1;
                        OE_AD_N    <= 4'b1111;
                        AD_O       <= '0;
                    end else begin
                        state    <= RD_DATA;
                        TRDY_O_N <= 1'b0;
                        AD_O     <= regs[idx];
                    end
                end

                RD_DATA: begin
                    if (!IRDY_I_N && !TRDY_O_N) begin
                        OE_AD_N  <= 4'b1111;
                        AD_O     <= '0;
                        TRDY_O_N <= 1'b1;
                        if (!FRAME_I_N) begin
                            state    <= BACKOFF;
                            STOP_O_N <= 1'b0;
                        end else begin
                            state      <= TURNAR;
                            DEVSEL_O_N <= 1'b1;
                        end
                    end else if (FRAME_I_N && IRDY_I_N) begin
                        state      <= TURNAR;
                        DEVSEL_O_N <= 1'b1;
                        TRDY_O_N   <= 1'b1;
                        OE_AD_N    <= 4'b1111;
                        AD_O       <= '0;
                    end else begin
                        AD_O <= regs[idx];
                    end
                end

                BACKOFF: begin
                    if (FRAME_I_N) begin
                        state      <= TURNAR;
                        DEVSEL_O_N <= 1'b1;
                        STOP_O_N   <= 1'b1;
                    end
                end

                TURNAR: begin
                    OE_DEVSEL_N <= 1'b1;
                    OE_TRDY_N   <= 1'b1;
                    OE_STOP_N   <= 1'b1;
                    state       <= FRAME_I_N ? IDLE : BUSY;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pci_io_target.sv
// Self-checking bench for pci_io_target: directed bus cycles plus random
// I/O accesses compared against an array model of the register file.
module tb_pci_io_target;

    localparam logic [31:0] BASE = 32'h0000_0200;
    localparam int          N    = 4;
    localparam logic [31:0] RV   = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     ad_i, ad_o;
    logic [3:0]      oe_ad_n, cbe_i;
    logic            frame_n, irdy_n;
    logic            par_o, oe_par_n;
    logic            devsel_n, oe_devsel_n, trdy_n, oe_trdy_n, stop_n, oe_stop_n;
    logic [32*N-1:0] reg_q;
    logic [N-1:0]    wr_stb;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [31:0] model [N];

    always #5 clk = ~clk;

    pci_io_target #(.BASE_ADDR(BASE), .NUM_REGS(N), .RESET_VAL(RV)) dut (
        .CLK(clk), .RST(rst),
        .AD_I(ad_i), .AD_O(ad_o), .OE_AD_N(oe_ad_n), .CBE_I(cbe_i),
        .FRAME_I_N(frame_n), .IRDY_I_N(irdy_n),
        .PAR_O(par_o), .OE_PAR_N(oe_par_n),
        .DEVSEL_O_N(devsel_n), .OE_DEVSEL_N(oe_devsel_n),
        .TRDY_O_N(trdy_n), .OE_TRDY_N(oe_trdy_n),
        .STOP_O_N(stop_n), .OE_STOP_N(oe_stop_n),
        .REG_Q(reg_q), .WR_STB(wr_stb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < N; i++) check(tag, reg_q[32*i +: 32], model[i]);
    endtask

    task automatic check_released(input string tag);
        check({tag, " oe_devsel"}, 32'(oe_devsel_n), 32'd1);
        check({tag, " oe_trdy"},   32'(oe_trdy_n),   32'd1);
        check({tag, " oe_stop"},   32'(oe_stop_n),   32'd1);
        check({tag, " oe_ad"},     32'(oe_ad_n),     32'hF);
    endtask

    task automatic idle_bus();
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        cbe_i   = 4'h0;
        ad_i    = 32'h0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] be_n);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (!be_n[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // One complete master transaction; expectations come from the model and the address rules.
    task automatic do_txn(input logic [31:0] addr, input logic [3:0] cmd, input logic [3:0] be,
                          input logic [31:0] data, input bit burst);
        bit          in_range, hit, is_wr;
        int          idx;
        logic [31:0] rd_val;
        in_range = (addr >= BASE) && (addr < BASE + 4 * N);
        is_wr    = (cmd == 4'b0011);
        hit      = in_range && (cmd == 4'b0011 || cmd == 4'b0010);
        idx      = in_range ? int'((addr - BASE) >> 2) : 0;

        frame_n = 1'b0; irdy_n = 1'b1; ad_i = addr; cbe_i = cmd;
        @(negedge clk);
        if (!hit) begin
            check_released("miss addr+1");
            frame_n = 1'b1; irdy_n = 1'b0; ad_i = data; cbe_i = be;
            @(negedge clk);
            check_released("miss data");
            check("miss wr_stb", 32'(wr_stb), 32'd0);
            idle_bus();
            @(negedge clk);
            check_regs("miss regs");
            return;
        end
        check("devsel addr+1", 32'(devsel_n), 32'd0);
        check("oe_devsel addr+1", 32'(oe_devsel_n), 32'd0);

        if (is_wr) begin
            check("wr trdy addr+1", 32'(trdy_n), 32'd0);
            frame_n = !burst; irdy_n = 1'b0; ad_i = data; cbe_i = be;
            @(negedge clk);
            model[idx] = merge(model[idx], data, be);
            check("wr reg", reg_q[32*idx +: 32], model[idx]);
            check("wr stb", 32'(wr_stb), 32'(1 << idx));
            check("wr stop", 32'(stop_n), burst ? 32'd0 : 32'd1);
            check("wr devsel post", 32'(devsel_n), burst ? 32'd0 : 32'd1);
            if (burst) begin
                frame_n = 1'b1; irdy_n = 1'b0; ad_i = ~data; cbe_i = 4'h0;
                @(negedge clk);
                check("burst devsel off", 32'(devsel_n), 32'd1);
                check("burst wr_stb", 32'(wr_stb), 32'd0);
                check("burst one write", reg_q[32*idx +: 32], model[idx]);
            end
            idle_bus();
            @(negedge clk);
            check("wr stb end", 32'(wr_stb), 32'd0);
            check_released("wr end");
        end else begin
            rd_val = model[idx];
            check("rd trdy turn", 32'(trdy_n), 32'd1);
            check("rd oe_ad turn", 32'(oe_ad_n), 32'h0);
            check("rd ad turn", ad_o, rd_val);
            frame_n = !burst; irdy_n = 1'b0; ad_i = $urandom; cbe_i = be;
            @(negedge clk);
            check("rd trdy", 32'(trdy_n), 32'd0);
            check("rd ad", ad_o, rd_val);
            check("rd par", 32'(par_o), 32'(^{rd_val, be}));
            check("rd oe_par", 32'(oe_par_n), 32'd0);
            @(negedge clk);
            check("rd ad release", 32'(oe_ad_n), 32'hF);
            check("rd par last", 32'(par_o), 32'(^{rd_val, be}));
            check("rd oe_par last", 32'(oe_par_n), 32'd0);
            check("rd stop", 32'(stop_n), burst ? 32'd0 : 32'd1);
            if (burst) begin
                frame_n = 1'b1; irdy_n = 1'b0;
                @(negedge clk);
                check("rd burst devsel off", 32'(devsel_n), 32'd1);
            end
            idle_bus();
            @(negedge clk);
            check("rd oe_par off", 32'(oe_par_n), 32'd1);
            check_released("rd end");
        end
        check_regs("txn regs");
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  c;
        logic [3:0]  cmds [6];
        cmds = '{4'b0011, 4'b0010, 4'b0011, 4'b0010, 4'b0111, 4'b0110};
        for (int i = 0; i < N; i++) model[i] = RV;

        rst = 1'b1;
        idle_bus();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_regs("reset regs");
        check_released("reset");
        check("reset wr_stb", 32'(wr_stb), 32'd0);
        check("reset devsel", 32'(devsel_n), 32'd1);
        check("reset trdy", 32'(trdy_n), 32'd1);
        check("reset stop", 32'(stop_n), 32'd1);
        check("reset ad_o", ad_o, 32'd0);
        check("reset par", 32'(par_o), 32'd0);
        check("reset oe_par", 32'(oe_par_n), 32'd1);
        @(negedge clk);

        do_txn(32'h204, 4'b0011, 4'b0000, 32'hDEADBEEF, 1'b0);
        do_txn(32'h200, 4'b0011, 4'b1100, 32'h12345678, 1'b0);
        check("reg0 partial", reg_q[31:0], 32'h0000_5678);
        do_txn(32'h20C, 4'b0011, 4'b0000, 32'h0000_00FF, 1'b0);
        do_txn(32'h20C, 4'b0010, 4'b0000, 32'h0, 1'b0);
        do_txn(32'h210, 4'b0011, 4'b0000, 32'hCAFEF00D, 1'b0);
        do_txn(32'h200, 4'b0111, 4'b0000, 32'hCAFEF00D, 1'b0);
        do_txn(32'h200, 4'b0011, 4'b0000, 32'hA5A5_5A5A, 1'b1);
        do_txn(32'h208, 4'b0010, 4'b1010, 32'h0, 1'b1);

        // Master abort: address hit, then FRAME and IRDY both released without a transfer.
        frame_n = 1'b0; irdy_n = 1'b1; ad_i = 32'h208; cbe_i = 4'b0011;
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        check("abort devsel", 32'(devsel_n), 32'd1);
        check("abort wr_stb", 32'(wr_stb), 32'd0);
        @(negedge clk);
        check_released("abort end");
        check_regs("abort regs");

        // Reset landing on the edge of a write transfer.
        frame_n = 1'b0; irdy_n = 1'b1; ad_i = 32'h204; cbe_i = 4'b0011;
        @(negedge clk);
        frame_n = 1'b1; irdy_n = 1'b0; ad_i = 32'h1111_2222; cbe_i = 4'b0000; rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) model[i] = RV;
        check_regs("rst mid regs");
        check("rst mid wr_stb", 32'(wr_stb), 32'd0);
        check_released("rst mid");
        rst = 1'b0;
        idle_bus();
        @(negedge clk);

        // Reset released while FRAME is low: the target must wait for an idle bus.
        frame_n = 1'b0; irdy_n = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ad_i = 32'h200; cbe_i = 4'b0011;
        @(negedge clk);
        check("post rst busy oe_devsel", 32'(oe_devsel_n), 32'd1);
        @(negedge clk);
        check("post rst busy oe_trdy", 32'(oe_trdy_n), 32'd1);
        idle_bus();
        @(negedge clk);
        check_regs("post rst regs");

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) a = $urandom & 32'hFFFF_FFFC;
            else a = BASE - 32'd8 + 32'(4 * $urandom_range(0, N + 3));
            c = cmds[$urandom_range(0, 5)];
            do_txn(a, c, 4'($urandom), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pci_io_target.md
PCI_IO_TARGET -- requirements
Module: pci_io_target

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0200; byte address of register 0, aligned to 4*NUM_REGS.
REQ-002 Parameter NUM_REGS, default 4; number of 32-bit registers, power of two, 1..16.
REQ-003 Parameter RESET_VAL, default 32'h0000_0000; reset contents of every register.
REQ-004 CLK  in  1  PCI clock; all logic on rising edge; single clock domain.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 AD_I  in  32 / AD_O  out  32 / OE_AD_N  out  4  address/data bus; OE active low per byte lane.
REQ-007 CBE_I  in  4  command / byte enables, active low.
REQ-008 FRAME_I_N, IRDY_I_N  in  1 each  master framing and ready, active low.
REQ-009 PAR_O, OE_PAR_N  out  1 each  read-data parity and its enable.
REQ-010 DEVSEL_O_N, OE_DEVSEL_N, TRDY_O_N, OE_TRDY_N, STOP_O_N, OE_STOP_N  out  1 each  target control and enables.
REQ-011 REG_Q  out  32*NUM_REGS  register contents; register i at bits [32i+31:32i].
REQ-012 WR_STB  out  NUM_REGS  one-cycle pulse on the cycle a register is written.

Function
REQ-013 States: IDLE, BUSY, WR_DATA, RD_TURN, RD_DATA, BACKOFF, TURNAR.
REQ-014 IDLE, FRAME_I_N=0: hit when CBE_I is 4'b0011 (IO write) or 4'b0010 (IO read) and AD_I[31:2] is in [BASE_ADDR, BASE_ADDR+4*NUM_REGS); latch index AD_I[log2(NUM_REGS)+1:2].
REQ-015 Hit + write goes to WR_DATA; hit + read goes to RD_TURN; miss or other command goes to BUSY.
REQ-016 BUSY returns to IDLE on the first cycle with FRAME_I_N=1 and IRDY_I_N=1; outputs stay released.
REQ-017 DEVSEL is fast decode: DEVSEL_O_N=0 and OE_DEVSEL_N=0 on the cycle after the address phase.
REQ-018 WR_DATA: TRDY_O_N=0 from the first data cycle.
REQ-019 RD_TURN: TRDY stays high for one cycle; AD drive starts (OE_AD_N=4'b0000, AD_O = selected register); then RD_DATA asserts TRDY_O_N=0.
REQ-020 Data transfer = IRDY_I_N=0 and TRDY_O_N=0 at the clock edge.
REQ-021 Write transfer: each byte lane n with CBE_I[n]=0 updates register byte n; other lanes hold; WR_STB[index]=1 for the next cycle only.
REQ-022 Read transfer: AD_O holds register value; byte enables are ignored; the read has no side effects.
REQ-023 Parity: on the cycle after any cycle with OE_AD_N=0, PAR_O = XOR of previous AD_O and CBE_I, with OE_PAR_N=0.
REQ-024 Single data phase only: if FRAME_I_N=0 at the transfer, assert STOP_O_N=0 (OE_STOP_N=0) with TRDY (disconnect with data).
REQ-025 BACKOFF: TRDY_O_N=1; DEVSEL and STOP stay asserted until FRAME_I_N=1.
REQ-026 TURNAR: the cycle after FRAME_I_N=1 and IRDY_I_N=1, drive DEVSEL, TRDY and STOP high for one cycle, then release all OE; go to IDLE.
REQ-027 On the cycle after the last read transfer, release AD (OE_AD_N=4'b1111); PAR stays driven one more cycle per REQ-023.
REQ-028 If FRAME_I_N=1 and IRDY_I_N=1 while DEVSEL is asserted (master abort), go straight to TURNAR with no register update.
REQ-029 Back-to-back: a new address phase during TURNAR is ignored (fast back-to-back not supported) and treated as a miss via BUSY.
REQ-030 Outputs are registered; no combinational path from inputs to any *_O_N, AD_O, PAR_O or OE output.

Reset
REQ-031 RST=1 on an edge: state IDLE; all registers = RESET_VAL; WR_STB=0; all *_O_N=1; all OE_*=released (1/4'b1111); AD_O=0; PAR_O=0.
REQ-032 RST mid-transaction aborts at once, with no partial write; after release, wait for bus idle (BUSY rule) if FRAME_I_N=0.

Verification
REQ-033 IO write 0x204, CBE=0000, data 0xDEADBEEF, IRDY low -> DEVSEL on cycle+1, TRDY on cycle+1, REG_Q[63:32]=0xDEADBEEF, WR_STB=4'b0010 for one cycle.
REQ-034 IO write 0x200 with CBE=1100, data 0x12345678, reg0=0 -> reg0=0x00005678.
REQ-035 IO read 0x20C with reg3=0x0000_00FF -> AD driven on cycle+1, TRDY on cycle+2, AD_O=0x000000FF, PAR_O equals XOR of AD_O and CBE one cycle later.
REQ-036 IO write 0x210 (out of range), and a memory write (0111) to 0x200 -> DEVSEL and all OE stay high; registers unchanged.
REQ-037 Burst IO write to 0x200 with FRAME low across two data phases -> STOP+TRDY on first transfer, one register write only, DEVSEL released one cycle after FRAME high.
REQ-038 RST asserted on the cycle of a write transfer -> registers = RESET_VAL, WR_STB=0, all OE released next cycle.
